// File: rtl/button_step_ctrl.sv
// button_step_ctrl: sync+debounce step button into one-cycle step_pulse, sync switches, count steps; BUTTON_STEP_AUTO_REPEAT_EN adds held-button auto-repeat
module button_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W = 6,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            fastclk,
  input  logic            rst,
  input  logic            btn_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            step_pulse,
  output logic            btn_level,
  output logic [SW_W-1:0] sw_sync,
  output logic [15:0]     step_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state, state_n;
  logic [1:0] bsync;
  logic s;
  logic [SW_W-1:0] sw_meta;
  logic [CW-1:0] cnt, cnt_n;
  logic cnt_done, pulse_n;
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_step_ctrl: parameter out of range");
  end
  assign s = bsync[1];
  assign cnt_done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign btn_level = state == PRESSED || state == RELEASE_WAIT;
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt, rcnt_n;
  logic rfirst, rfirst_n;
  always_ff @(posedge fastclk) begin
    if (rst) begin
      rcnt <= '0;
      rfirst <= 1'b0;
    end else begin
      rcnt <= rcnt_n;
      rfirst <= rfirst_n;
    end
  end
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = s ? PRESS_WAIT : IDLE;
        cnt_n = s ? '0 : cnt;
      end
      PRESS_WAIT: begin
        state_n = !s ? IDLE : cnt_done ? PRESSED : PRESS_WAIT;
        pulse_n = s && cnt_done;
        cnt_n = s && !cnt_done ? cnt + 1'b1 : cnt;
      end
      PRESSED: begin
        state_n = s ? PRESSED : RELEASE_WAIT;
        cnt_n = s ? cnt : '0;
      end
      default: begin
        state_n = s ? PRESSED : cnt_done ? IDLE : RELEASE_WAIT;
        cnt_n = !s && !cnt_done ? cnt + 1'b1 : cnt;
      end
    endcase
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
    rcnt_n = rcnt;
    rfirst_n = rfirst;
    if (state != PRESSED && state_n == PRESSED) begin
      rcnt_n = '0;
      rfirst_n = 1'b1;
    end else if (state == PRESSED && state_n != PRESSED) begin
      rcnt_n = '0;
    end else if (state == PRESSED) begin
      if (rcnt == (rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
        pulse_n = 1'b1;
        rcnt_n = '0;
        rfirst_n = 1'b0;
      end else begin
        rcnt_n = rcnt + 1'b1;
      end
    end
`endif
  end
  always_ff @(posedge fastclk) begin
    if (rst) begin
      bsync <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      state <= IDLE;
      cnt <= '0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      bsync <= {bsync[0], btn_raw};
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
      state <= state_n;
      cnt <= cnt_n;
      step_pulse <= pulse_n;
      step_count <= step_count + {15'd0, step_pulse};
    end
  end
endmodule

// File: tb/tb_button_step_ctrl.sv
// tb_button_step_ctrl: directed stimulus with pulse scoreboard for button_step_ctrl
module tb_button_step_ctrl;
  localparam int D = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int W = 6;
  logic fastclk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic step_pulse, btn_level;
  logic [W-1:0] sw_sync;
  logic [15:0] step_count;
  typedef struct {int at; int cnt;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_count = 0;
  int base;
  button_step_ctrl #(.DEBOUNCE_CYCLES(D), .SW_W(W), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .fastclk(fastclk),
    .rst(rst),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .step_pulse(step_pulse),
    .btn_level(btn_level),
    .sw_sync(sw_sync),
    .step_count(step_count)
  );
  always #5 fastclk = ~fastclk;
  always @(posedge fastclk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask
  task automatic expect_press(input int b, input int h);
    int e;
    q.push_back('{b + D + 3, exp_count});
    exp_count++;
`ifdef BUTTON_STEP_AUTO_REPEAT_EN
    e = b + D + 3 + RD;
    while (e <= b + h + 2) begin
      q.push_back('{e, exp_count});
      exp_count++;
      e += RP;
    end
`else
    e = h;
`endif
  endtask
  always @(negedge fastclk) begin : monitor
    exp_t x;
    if (step_pulse) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
      end else begin
        x = q.pop_front();
        chk("pulse_cycle", cyc, x.at);
        chk("pulse_count", {16'd0, step_count}, x.cnt);
      end
    end
  end
  initial begin
    tick(3);
    chk("rst_pulse", {31'd0, step_pulse}, 0);
    chk("rst_level", {31'd0, btn_level}, 0);
    chk("rst_sw", {26'd0, sw_sync}, 0);
    chk("rst_count", {16'd0, step_count}, 0);
    rst = 1'b0;
    tick(2);
    base = cyc;
    expect_press(base, 20);
    btn_raw = 1'b1;
    tick(6);
    chk("level_before", {31'd0, btn_level}, 0);
    tick(1);
    chk("level_rise", {31'd0, btn_level}, 1);
    tick(13);
    btn_raw = 1'b0;
    tick(6);
    chk("level_hold", {31'd0, btn_level}, 1);
    tick(1);
    chk("level_fall", {31'd0, btn_level}, 0);
    tick(3);
    chk("count_clean", {16'd0, step_count}, exp_count);
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      tick(2);
    end
    base = cyc;
    expect_press(base, 12);
    btn_raw = 1'b1;
    tick(12);
    btn_raw = 1'b0;
    tick(12);
    chk("count_bounce", {16'd0, step_count}, exp_count);
    base = cyc;
    expect_press(base, 0);
    btn_raw = 1'b1;
    tick(12);
    btn_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) btn_raw = 1'b1;
      tick(1);
      chk("glitch_level", {31'd0, btn_level}, 1);
    end
    btn_raw = 1'b0;
    tick(12);
    chk("glitch_released", {31'd0, btn_level}, 0);
    base = cyc;
    expect_press(base, 10);
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(12);
    chk("count_second", {16'd0, step_count}, exp_count);
    sw_raw = 6'b110011;
    btn_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_level", {31'd0, btn_level}, 0);
    chk("midrst_count", {16'd0, step_count}, 0);
    chk("midrst_sw", {26'd0, sw_sync}, 0);
    chk("midrst_pulse", {31'd0, step_pulse}, 0);
    exp_count = 0;
    rst = 1'b0;
    base = cyc;
    expect_press(base, 14);
    tick(14);
    btn_raw = 1'b0;
    tick(12);
    chk("count_after_rst", {16'd0, step_count}, exp_count);
    sw_raw = 6'b101101;
    tick(1);
    chk("sw_lat1", {26'd0, sw_sync}, 32'b110011);
    tick(1);
    chk("sw_lat2", {26'd0, sw_sync}, 32'b101101);
    sw_raw = 6'b010010;
    tick(1);
    sw_raw = 6'b101101;
    chk("sw_blip1", {26'd0, sw_sync}, 32'b101101);
    tick(1);
    chk("sw_blip2", {26'd0, sw_sync}, 32'b010010);
    tick(1);
    chk("sw_blip3", {26'd0, sw_sync}, 32'b101101);
    base = cyc;
    expect_press(base, 30);
    btn_raw = 1'b1;
    tick(30);
    btn_raw = 1'b0;
    tick(12);
    chk("count_long", {16'd0, step_count}, exp_count);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_step_ctrl.md
# button_step_ctrl

Input-conditioning block sitting between the board's raw pushbutton and slide switches and the single-cycle processor. It synchronises and debounces the step button with a counter-based state machine, emitting exactly one `fastclk`-wide `step_pulse` per clean press. That pulse is the processor's single-step enable. Switch levels are synchronised into `sw_sync` for LED and seven-segment selection. A 16-bit press counter is kept for display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a press or release; must be ≥ 2.
- `SW_W`, 6: switch bus width (2 LED-select + 4 SSD-select).
- `REPEAT_DELAY`, 25000000: hold cycles before the first auto-repeat pulse; must be ≥ 1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent auto-repeat pulses; must be ≥ 1.

Ports:
- `fastclk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in 1: asynchronous, bouncing step button; high = pressed.
- `sw_raw` in `SW_W`: asynchronous slide switches.
- `step_pulse` out 1: registered; high for exactly one cycle per accepted step.
- `btn_level` out 1: debounced button level; high in PRESSED and RELEASE_WAIT.
- `sw_sync` out `SW_W`: two-flop-synchronised switches.
- `step_count` out 16: number of `step_pulse` assertions since reset.

## Operation
- **Synchroniser.** `btn_raw` passes through two flops to produce `s`. `sw_raw` passes through two flops to produce `sw_sync`. Switches are not debounced.
- **Debounce counter.** `cnt` is sized by `$clog2(DEBOUNCE_CYCLES)`.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if `s`=1, go to PRESS_WAIT with `cnt`←0.
  - PRESS_WAIT:
    - `s`=0 → IDLE.
    - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED, and `step_pulse`←1 on the same edge.
    - Otherwise `cnt`++.
  - PRESSED: if `s`=0, go to RELEASE_WAIT with `cnt`←0.
  - RELEASE_WAIT:
    - `s`=1 → PRESSED, with no pulse.
    - `s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE.
    - Otherwise `cnt`++.
- **Press counter.** `step_count` increments on the edge after each `step_pulse` high cycle. It wraps 0xFFFF→0x0000 with no flag.
- **Release glitches.** A bounce on release never produces a second pulse. Re-entering PRESSED from RELEASE_WAIT is silent.
- **Reset.**
  - All flops clear on the reset edge: sync stages, `cnt`, repeat counter, `step_count`, `step_pulse`, and FSM→IDLE.
  - Output reset values: `step_pulse`=0, `btn_level`=0, `sw_sync`=0, `step_count`=0.
  - Reset has priority over every transition, including reset asserted mid-PRESS_WAIT or mid-PRESSED.
  - If the button is still held after reset releases, it is treated as a new press and produces one pulse after full debounce.

## Timing
- Edge numbering: `btn_raw` rises and stays high before edge 1.
- `s`=1 after edge 2.
- PRESS_WAIT is entered at edge 3.
- PRESSED is entered at edge `DEBOUNCE_CYCLES`+3; `step_pulse` is high for the cycle following that edge.
- Press latency is therefore `DEBOUNCE_CYCLES`+3 cycles.
- `btn_level` rises on the same edge as `step_pulse`.
- Release: `btn_level` falls `DEBOUNCE_CYCLES`+3 edges after `btn_raw` falls stably.
- `sw_sync` latency is 2 cycles.
- `step_pulse` is never high on two consecutive cycles.

## Configuration
Macro `BUTTON_STEP_AUTO_REPEAT_EN`.
- **Defined:** while the FSM is in PRESSED, a repeat counter runs.
  - It clears on entry to PRESSED and increments every cycle.
  - When it equals `REPEAT_DELAY`-1 (first repeat) or `REPEAT_PERIOD`-1 (subsequent repeats), `step_pulse`←1 on the next edge and the counter clears.
  - Entering RELEASE_WAIT freezes and clears the counter.
  - A bounce back into PRESSED restarts the delay phase.
- **Undefined:**
  - No repeat logic is synthesised.
  - Exactly one pulse per debounced press.
  - `REPEAT_*` parameters are ignored.

## Test plan
- `DEBOUNCE_CYCLES`=4; `btn_raw` held high 20 cycles from edge 1 → `step_pulse` high only after edge 7; `btn_level` rises at edge 7; `step_count`=1.
- `DEBOUNCE_CYCLES`=4; `btn_raw` toggles every 2 cycles for 10 cycles, then stays high → no pulse during bouncing; exactly one pulse, 7 edges after the final rise; `step_count`=1.
- While PRESSED, `btn_raw` glitches low for 2 cycles, then returns high → no pulse, `btn_level` stays 1. After a clean release and a second press → `step_count`=2.
- `rst` asserted for one cycle while in PRESS_WAIT → next edge: FSM IDLE, `step_count`=0, `sw_sync`=0, no pulse. Button still held → one pulse `DEBOUNCE_CYCLES`+3 edges after reset deasserts.
- `sw_raw`=6'b101101 applied → `sw_sync`=6'b101101 after 2 edges; a 1-cycle `sw_raw` change propagates unfiltered 2 cycles later.
- `BUTTON_STEP_AUTO_REPEAT_EN` defined, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, button held 30 cycles → pulses after edges 7, 17, 22, 27, 32 while held; `step_count` matches the number of pulses. With the macro undefined, the same stimulus gives a single pulse at edge 7.
